// File: rtl/instr_fetch_queue.sv
// In-order instruction fetch queue: issues imem reads for fetch PCs and buffers {pc, instr}
// pairs for decode; flushes on redirect. Optional IFQ_ALIGN_CHECK_EN adds misaligned-PC tagging.
module instr_fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] pc_i,
  input  logic        pc_valid_i,
  output logic        pc_ready_o,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        flush_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o
`ifdef IFQ_ALIGN_CHECK_EN
  ,
  output logic        instr_misalign_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]    count_q, count_d, discard_q, discard_d;
  logic [DEPTH-1:0] filled_q, filled_d, pending_q, pending_d;
  logic [31:0]      slot_pc_q [DEPTH];
  logic [31:0]      slot_pc_d [DEPTH];
  logic [31:0]      slot_instr_q [DEPTH];
  logic [31:0]      slot_instr_d [DEPTH];
`ifdef IFQ_ALIGN_CHECK_EN
  logic [DEPTH-1:0] slot_mis_q, slot_mis_d;
`endif

  logic          misal, accept, issue, pop, fill_hit;
  logic [AW-1:0] fill_idx, scan_idx;
  logic [CW:0]   outstanding;

  assign imem_addr_o = pc_i;

  // Discarded responses still occupy memory-side capacity, so they count against space.
  always_comb begin
`ifdef IFQ_ALIGN_CHECK_EN
    misal = (pc_i[1:0] != 2'b00);
`else
    misal = 1'b0;
`endif
    accept        = pc_valid_i & ~rst_i & ~flush_i &
                    (({1'b0, count_q} + {1'b0, discard_q}) < (CW+1)'(DEPTH));
    imem_req_o    = accept & ~misal;
    pc_ready_o    = (imem_req_o & imem_gnt_i) | (accept & misal);
    issue         = pc_ready_o;
    instr_valid_o = (count_q != '0) & filled_q[rd_q];
    pop           = instr_valid_o & instr_ready_i & ~flush_i;
    instr_o       = instr_valid_o ? slot_instr_q[rd_q] : 32'h0;
    instr_pc_o    = instr_valid_o ? slot_pc_q[rd_q] : 32'h0;
`ifdef IFQ_ALIGN_CHECK_EN
    instr_misalign_o = instr_valid_o & slot_mis_q[rd_q];
`endif
  end

  // Oldest pending slot (scanning from the head) receives the next non-discarded response.
  always_comb begin
    fill_hit    = 1'b0;
    fill_idx    = rd_q;
    scan_idx    = rd_q;
    outstanding = {1'b0, discard_q};
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx    = rd_q + AW'(k);
      outstanding = outstanding + (CW+1)'(pending_q[k]);
      if (!fill_hit && pending_q[scan_idx]) begin
        fill_hit = 1'b1;
        fill_idx = scan_idx;
      end
    end
  end

  always_comb begin
    rd_d         = rd_q;
    wr_d         = wr_q;
    count_d      = count_q;
    discard_d    = discard_q;
    filled_d     = filled_q;
    pending_d    = pending_q;
    slot_pc_d    = slot_pc_q;
    slot_instr_d = slot_instr_q;
`ifdef IFQ_ALIGN_CHECK_EN
    slot_mis_d   = slot_mis_q;
`endif
    if (flush_i) begin
      rd_d      = '0;
      wr_d      = '0;
      count_d   = '0;
      filled_d  = '0;
      pending_d = '0;
      discard_d = CW'(outstanding - (CW+1)'(imem_rvalid_i && (outstanding != '0)));
    end else begin
      if (imem_rvalid_i) begin
        if (discard_q != '0) begin
          discard_d = discard_q - 1'b1;
        end else if (fill_hit) begin
          filled_d[fill_idx]     = 1'b1;
          pending_d[fill_idx]    = 1'b0;
          slot_instr_d[fill_idx] = imem_rdata_i;
        end
      end
      if (issue) begin
        slot_pc_d[wr_q] = pc_i;
        filled_d[wr_q]  = misal;
        pending_d[wr_q] = ~misal;
        wr_d            = wr_q + 1'b1;
`ifdef IFQ_ALIGN_CHECK_EN
        slot_mis_d[wr_q] = misal;
        if (misal) slot_instr_d[wr_q] = 32'h0;
`endif
      end
      if (pop) begin
        filled_d[rd_q] = 1'b0;
        rd_d           = rd_q + 1'b1;
      end
      count_d = count_q + CW'(issue) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_q      <= '0;
      wr_q      <= '0;
      count_q   <= '0;
      discard_q <= '0;
      filled_q  <= '0;
      pending_q <= '0;
    end else begin
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      count_q   <= count_d;
      discard_q <= discard_d;
      filled_q  <= filled_d;
      pending_q <= pending_d;
    end
  end

  // Slot payload needs no reset: it is only visible through filled/valid qualification.
  always_ff @(posedge clk_i) begin
    slot_pc_q    <= slot_pc_d;
    slot_instr_q <= slot_instr_d;
`ifdef IFQ_ALIGN_CHECK_EN
    slot_mis_q   <= slot_mis_d;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && imem_rvalid_i) assert (outstanding != '0);
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: stream, full, flush, backpressure, async reset and
// PC alignment handling (both with and without IFQ_ALIGN_CHECK_EN).
module tb_instr_fetch_queue;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] pc_i;
  logic        pc_valid_i;
  logic        pc_ready_o;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        flush_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
`ifdef IFQ_ALIGN_CHECK_EN
  logic        instr_misalign_o;
`endif

  int n_checks = 0;
  int n_errors = 0;

  instr_fetch_queue #(.DEPTH(4)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .pc_i          (pc_i),
    .pc_valid_i    (pc_valid_i),
    .pc_ready_o    (pc_ready_o),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .flush_i       (flush_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o)
`ifdef IFQ_ALIGN_CHECK_EN
    ,
    .instr_misalign_o (instr_misalign_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    pc_valid_i    = 1'b0;
    pc_i          = 32'h0;
    imem_gnt_i    = 1'b1;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    flush_i       = 1'b0;
    instr_ready_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got %0d expected %0d", 1, 0);
    $fatal(1);
  end

  initial begin
    int issued, popped;
    logic        pend_v;
    logic [31:0] pend_pc;

    idle();
    rst_i      = 1'b1;
    pc_valid_i = 1'b1;
    #12;
    check("rst_pc_ready", 32'(pc_ready_o), 32'd0);
    check("rst_req", 32'(imem_req_o), 32'd0);
    check("rst_valid", 32'(instr_valid_o), 32'd0);
    check("rst_instr", instr_o, 32'h0);
    check("rst_pc", instr_pc_o, 32'h0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    idle();
    tick();

    // 1: stream 0,4,8,C with one-cycle response latency
    for (int i = 0; i < 7; i++) begin
      pc_valid_i    = (i < 4);
      pc_i          = 32'(4 * i);
      imem_rvalid_i = (i >= 1 && i <= 4);
      imem_rdata_i  = 32'h1000 + 32'(i - 1);
      instr_ready_i = 1'b1;
      #1;
      check("s_rdy", 32'(pc_ready_o), 32'(i < 4));
      if (i < 4) check("s_addr", imem_addr_o, 32'(4 * i));
      if (i >= 2 && i <= 5) begin
        check("s_valid", 32'(instr_valid_o), 32'd1);
        check("s_pc", instr_pc_o, 32'(4 * (i - 2)));
        check("s_instr", instr_o, 32'h1000 + 32'(i - 2));
      end else begin
        check("s_idle", 32'(instr_valid_o), 32'd0);
      end
      tick();
    end
    idle();
    tick();

    // 2: full queue, ready low
    for (int k = 0; k < 5; k++) begin
      pc_valid_i = 1'b1;
      pc_i       = 32'h200 + 32'(4 * k);
      #1;
      check("f_rdy", 32'(pc_ready_o), 32'(k < 4));
      if (k == 4) check("f_req", 32'(imem_req_o), 32'd0);
      tick();
    end
    for (int j = 0; j < 4; j++) begin
      pc_i          = 32'h210;
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = 32'hA0 + 32'(j);
      #1;
      check("f_hold", 32'(pc_ready_o), 32'd0);
      tick();
    end
    imem_rvalid_i = 1'b0;
    instr_ready_i = 1'b1;
    #1;
    check("f_nobypass", 32'(pc_ready_o), 32'd0);
    check("f_pc0", instr_pc_o, 32'h200);
    check("f_in0", instr_o, 32'hA0);
    tick();
    #1;
    check("f_reopen", 32'(pc_ready_o), 32'd1);
    check("f_pc1", instr_pc_o, 32'h204);
    check("f_in1", instr_o, 32'hA1);
    tick();
    pc_valid_i    = 1'b0;
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'hA4;
    #1;
    check("f_pc2", instr_pc_o, 32'h208);
    check("f_in2", instr_o, 32'hA2);
    tick();
    imem_rvalid_i = 1'b0;
    #1;
    check("f_pc3", instr_pc_o, 32'h20C);
    check("f_in3", instr_o, 32'hA3);
    tick();
    #1;
    check("f_pc4", instr_pc_o, 32'h210);
    check("f_in4", instr_o, 32'hA4);
    tick();
    #1;
    check("f_empty", 32'(instr_valid_o), 32'd0);
    idle();
    tick();

    // 3: flush with two reads in flight
    pc_valid_i = 1'b1; pc_i = 32'h300; instr_ready_i = 1'b1;
    tick();
    pc_i = 32'h304;
    tick();
    pc_i = 32'h308; flush_i = 1'b1;
    #1;
    check("fl_rdy", 32'(pc_ready_o), 32'd0);
    check("fl_req", 32'(imem_req_o), 32'd0);
    tick();
    flush_i = 1'b0; pc_i = 32'h100;
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD0001;
    #1;
    check("fl_newreq", 32'(pc_ready_o), 32'd1);
    check("fl_empty0", 32'(instr_valid_o), 32'd0);
    tick();
    pc_valid_i = 1'b0; imem_rdata_i = 32'hDEAD0002;
    #1;
    check("fl_drop1", 32'(instr_valid_o), 32'd0);
    tick();
    imem_rdata_i = 32'hBEEF0100;
    #1;
    check("fl_drop2", 32'(instr_valid_o), 32'd0);
    tick();
    imem_rvalid_i = 1'b0;
    #1;
    check("fl_valid", 32'(instr_valid_o), 32'd1);
    check("fl_pc", instr_pc_o, 32'h100);
    check("fl_instr", instr_o, 32'hBEEF0100);
    tick();
    #1;
    check("fl_done", 32'(instr_valid_o), 32'd0);
    idle();
    tick();

    // 4: backpressure, ready alternating
    issued = 0; popped = 0; pend_v = 1'b0; pend_pc = 32'h0;
    for (int c = 0; c < 40; c++) begin
      imem_rvalid_i = pend_v;
      imem_rdata_i  = pend_pc ^ 32'h5A5A0000;
      pend_v        = 1'b0;
      pc_valid_i    = (issued < 8);
      pc_i          = 32'h400 + 32'(4 * issued);
      instr_ready_i = (c % 2 == 0);
      #1;
      if (pc_ready_o) begin
        pend_v  = 1'b1;
        pend_pc = pc_i;
        issued++;
      end
      if (instr_valid_o && instr_ready_i) begin
        check("bp_pc", instr_pc_o, 32'h400 + 32'(4 * popped));
        check("bp_instr", instr_o, (32'h400 + 32'(4 * popped)) ^ 32'h5A5A0000);
        popped++;
      end
      tick();
    end
    check("bp_count", 32'(popped), 32'd8);
    check("bp_drained", 32'(instr_valid_o), 32'd0);
    idle();
    tick();

    // 5: asynchronous reset with three entries queued
    pc_valid_i = 1'b1; pc_i = 32'h500;
    tick();
    pc_i = 32'h504; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h5000;
    tick();
    pc_i = 32'h508; imem_rdata_i = 32'h5004;
    tick();
    pc_valid_i = 1'b0; imem_rdata_i = 32'h5008;
    tick();
    imem_rvalid_i = 1'b0;
    #1;
    check("ar_pre", instr_pc_o, 32'h500);
    #2;
    rst_i = 1'b1; pc_valid_i = 1'b1;
    #1;
    check("ar_valid", 32'(instr_valid_o), 32'd0);
    check("ar_instr", instr_o, 32'h0);
    check("ar_pc", instr_pc_o, 32'h0);
    check("ar_rdy", 32'(pc_ready_o), 32'd0);
    check("ar_req", 32'(imem_req_o), 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0; pc_valid_i = 1'b0;
    #1;
    check("ar_empty", 32'(instr_valid_o), 32'd0);
    pc_valid_i = 1'b1; pc_i = 32'h600; instr_ready_i = 1'b1;
    #1;
    check("ar_newrdy", 32'(pc_ready_o), 32'd1);
    tick();
    pc_valid_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h66600;
    tick();
    imem_rvalid_i = 1'b0;
    #1;
    check("ar_newpc", instr_pc_o, 32'h600);
    check("ar_newin", instr_o, 32'h66600);
    tick();
    #1;
    check("ar_newdone", 32'(instr_valid_o), 32'd0);
    idle();
    tick();

    // 6: PC alignment handling for 0x0, 0x6, 0x8
    instr_ready_i = 1'b1;
    pc_valid_i = 1'b1; pc_i = 32'h0;
    tick();
    pc_i = 32'h6; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h11;
    #1;
    check("al_rdy6", 32'(pc_ready_o), 32'd1);
`ifdef IFQ_ALIGN_CHECK_EN
    check("al_req6", 32'(imem_req_o), 32'd0);
`else
    check("al_req6", 32'(imem_req_o), 32'd1);
    check("al_addr6", imem_addr_o, 32'h6);
`endif
    tick();
    pc_i = 32'h8;
`ifdef IFQ_ALIGN_CHECK_EN
    imem_rvalid_i = 1'b0;
`else
    imem_rdata_i = 32'h66;
`endif
    #1;
    check("al_pc0", instr_pc_o, 32'h0);
    check("al_in0", instr_o, 32'h11);
    tick();
    pc_valid_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h88;
    #1;
    check("al_pc6", instr_pc_o, 32'h6);
`ifdef IFQ_ALIGN_CHECK_EN
    check("al_in6", instr_o, 32'h0);
    check("al_mis6", 32'(instr_misalign_o), 32'd1);
`else
    check("al_in6", instr_o, 32'h66);
`endif
    tick();
    imem_rvalid_i = 1'b0;
    #1;
    check("al_pc8", instr_pc_o, 32'h8);
    check("al_in8", instr_o, 32'h88);
`ifdef IFQ_ALIGN_CHECK_EN
    check("al_mis8", 32'(instr_misalign_o), 32'd0);
`endif
    tick();
    #1;
    check("al_done", 32'(instr_valid_o), 32'd0);
    idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
